// File: rtl/nibble_serial_sub16.sv
// Digit-serial subtractor: diff = x - y - bin, one DIGIT-wide slice per clock,
// least significant digit first, borrow carried between digits in a register.
// Holds a single operation at a time behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | processing digit 'step' of the latched operands
// DONE  | result stable on diff/bout/ovf, out_valid high until out_ready
module nibble_serial_sub16 #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int STEPS  = WIDTH / DIGIT;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_cfg
         $error("nibble_serial_sub16: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    x_q, y_q;
   logic                borrow;
   logic [STEP_W-1:0]   step;
   logic [DIGIT-1:0]    x_dig, y_dig, d;
   logic [DIGIT:0]      sub;
   logic                b_out;
   logic                accept;
   logic                last_step;

   assign accept    = in_valid && in_ready;
   assign last_step = (step == STEP_W'(STEPS - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // One digit of subtraction on the currently selected slice.
   always_comb begin
      x_dig = x_q[step*DIGIT +: DIGIT];
      y_dig = y_q[step*DIGIT +: DIGIT];
      sub   = {1'b0, x_dig} - {1'b0, y_dig} - {{DIGIT{1'b0}}, borrow};
      d     = sub[DIGIT-1:0];
      b_out = sub[DIGIT];
   end

   // Operand capture and digit-by-digit result accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         borrow <= 1'b0;
         step   <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_q    <= x;
                  y_q    <= y;
                  borrow <= bin;
                  step   <= '0;
               end
            end
            CALC: begin
               diff[step*DIGIT +: DIGIT] <= d;
               borrow <= b_out;
               step   <= step + 1'b1;
               if (last_step) begin
                  bout <= b_out;
                  // d is the top digit being written now, so its MSB is diff's sign
                  ovf  <= (x_q[WIDTH-1] != y_q[WIDTH-1]) && (d[DIGIT-1] != x_q[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Directed bench for nibble_serial_sub16 with hand-computed expected results.
module tb_nibble_serial_sub16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x, y;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        ovf;

   int n_assert = 0;
   int n_fail   = 0;

   nibble_serial_sub16 #(.WIDTH(16), .DIGIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, check latency and result, stall 'stall' cycles, then handshake.
   task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                         input logic ba, input logic [15:0] ed, input logic eb,
                         input logic eo, input int stall);
      int cyc;
      logic [15:0] d_hold;
      @(negedge clk);
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
      x = xa; y = ya; bin = ba; in_valid = 1'b1;
      @(posedge clk);                       // E0: accept
      #1;
      in_valid = 1'b0;
      x = ~xa; y = xa ^ 16'h5A5A; bin = ~ba; // operands may change after accept
      cyc = 0;
      while (!out_valid && cyc < 12) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd4);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
      chk({tag, "_ovf"},  32'(ovf),  32'(eo));
      chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      d_hold = diff;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;                   // must be ignored outside IDLE
         x = 16'hFFFF; y = 16'h0000;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_stall_diff"},  32'(diff), 32'(ed));
         chk({tag, "_stall_bout"},  32'(bout), 32'(eb));
         chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      chk({tag, "_diff_held"}, 32'(diff), 32'(d_hold));
      out_ready = 1'b1;
      @(posedge clk);                       // handshake edge
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x = 16'h0; y = 16'h0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff",      32'(diff),      32'd0);
      chk("rst_bout",      32'(bout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("t1",      16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0);
      run_op("t2",      16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
      run_op("t3a",     16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
      run_op("t3b",     16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
      run_op("t4a",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
      run_op("t4b",     16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
      run_op("t_mix",   16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 0);
      run_op("t_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
      run_op("t5_bp",   16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 3);

      // Reset at E2 of an operation drops it.
      @(negedge clk);
      x = 16'h4321; y = 16'h1111; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);                       // E0
      #1;
      in_valid = 1'b0;
      @(posedge clk);                       // E1
      #1;
      reset = 1'b1;
      @(posedge clk);                       // E2 with reset
      #1;
      reset = 1'b0;
      chk("t6_in_ready",  32'(in_ready),  32'd1);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_diff",      32'(diff),      32'd0);
      @(posedge clk);
      #1;
      chk("t6_no_output", 32'(out_valid), 32'd0);
      run_op("t6_after",  16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
